nq_fetch_unit: RTL and testbench

Instruction fetch stage for the NanoQuarter CPU, upstream of the decode/register-read stage (Integration1). It holds the 256-word instruction memory, which is loaded externally through `write`/`exInst`. Once loaded, it fetches sequentially from PC 0 through a 4-entry prefetch FIFO and presents one instruction per cycle to decode. It honours decode stalls and flushes on branch/jump redirects driven by `PCNI` from the execute stage.

---
 rtl/nq_pkg.sv | 27 ++
 rtl/nq_fetch_unit_if.sv | 26 ++
 rtl/nq_fetch_fifo.sv | 59 +++++
 rtl/nq_fetch_unit.sv | 136 +++++++++++++
 tb/tb_nq_fetch_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/nq_pkg.sv
// Shared NanoQuarter definitions: datapath widths, load-word field positions,
// fetch state encoding and the prefetch entry layout.
package nq_pkg;

  localparam int unsigned INST_W     = 16;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned IMEM_AW    = 8;
  localparam int unsigned IMEM_DEPTH = 1 << IMEM_AW;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_CW    = $clog2(FIFO_DEPTH + 1);

  localparam int unsigned LD_ADDR_MSB = 23;
  localparam int unsigned LD_ADDR_LSB = 16;
  localparam int unsigned LD_DATA_MSB = 15;
  localparam int unsigned LD_DATA_LSB = 0;

  typedef enum logic {
    StLoad = 1'b0,
    StRun  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/nq_fetch_unit_if.sv
// Fetch-stage boundary: external IMEM load port, decode/execute controls and
// the instruction stream presented to decode.
interface nq_fetch_unit_if;
  import nq_pkg::*;

  logic              write;
  logic [31:0]       exInst;
  logic              stall;
  logic              redirect;
  logic [PC_W-1:0]   PCNI;
  logic [INST_W-1:0] inst_out;
  logic [PC_W-1:0]   PC_out;
  logic              valid_out;
  logic              running;

  modport master (
    output write, exInst, stall, redirect, PCNI,
    input  inst_out, PC_out, valid_out, running
  );

  modport slave (
    input  write, exInst, stall, redirect, PCNI,
    output inst_out, PC_out, valid_out, running
  );

endinterface

// File: rtl/nq_fetch_fifo.sv
// Prefetch FIFO for {pc, inst} entries; flush wins over push/pop.
// Depth must be a power of two so the pointers wrap naturally.
module nq_fetch_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 48,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [Width-1:0] data_i,
  output logic [CntW-1:0]  count_o,
  output logic [Width-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/nq_fetch_unit.sv
// NanoQuarter instruction fetch: externally loaded 256-word IMEM, LOAD/RUN
// control, sequential prefetch into a small FIFO, decode stall and redirect.
module nq_fetch_unit
  import nq_pkg::*;
(
  input logic            clk,
  input logic            rst,
  nq_fetch_unit_if.slave bus
);

  logic [INST_W-1:0] imem [IMEM_DEPTH];

  fetch_state_e      state_q, state_d;
  logic              loaded_q, loaded_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [PC_W-1:0]   rd_pc_q;
  logic [INST_W-1:0] rd_data_q;

  logic              issue, push, pop, flush;
  logic [FIFO_CW-1:0] fifo_count;
  logic [FIFO_CW:0]  occupancy;
  fetch_entry_t      head, rd_entry;
  logic              fifo_empty;
  logic              fifo_full_unused;
  logic              unused_ld_hi;

  logic [IMEM_AW-1:0] ld_addr;
  logic [INST_W-1:0]  ld_data;

  assign ld_addr      = bus.exInst[LD_ADDR_MSB:LD_ADDR_LSB];
  assign ld_data      = bus.exInst[LD_DATA_MSB:LD_DATA_LSB];
  assign unused_ld_hi = ^bus.exInst[31:24];

  // Entries already buffered plus the read still in flight bound new issues.
  assign occupancy = {1'b0, fifo_count} + (FIFO_CW + 1)'(inflight_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StLoad;
      loaded_q   <= 1'b0;
      fetch_pc_q <= '0;
      inflight_q <= 1'b0;
      rd_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      loaded_q   <= loaded_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      if (issue) begin
        rd_pc_q <= fetch_pc_q;
      end
    end
  end

  // IMEM image survives reset; only the control state is cleared.
  always_ff @(posedge clk) begin
    if (bus.write) begin
      imem[ld_addr] <= ld_data;
    end
    if (issue) begin
      rd_data_q <= imem[fetch_pc_q[IMEM_AW-1:0]];
    end
  end

  always_comb begin
    state_d    = state_q;
    loaded_d   = loaded_q;
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    issue      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      StLoad: begin
        if (bus.write) begin
          loaded_d = 1'b1;
        end else if (loaded_q) begin
          state_d    = StRun;
          fetch_pc_d = '0;
        end
      end
      StRun: begin
        if (bus.write) begin
          // A reload beats any redirect and discards everything in flight.
          state_d    = StLoad;
          loaded_d   = 1'b1;
          flush      = 1'b1;
          inflight_d = 1'b0;
          fetch_pc_d = '0;
        end else if (bus.redirect) begin
          flush      = 1'b1;
          inflight_d = 1'b0;
          fetch_pc_d = bus.PCNI;
        end else begin
          push       = inflight_q;
          pop        = !fifo_empty && !bus.stall;
          issue      = occupancy < (FIFO_CW + 1)'(FIFO_DEPTH);
          inflight_d = issue;
          if (issue) begin
            fetch_pc_d = fetch_pc_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  assign rd_entry = '{pc: rd_pc_q, inst: rd_data_q};

  nq_fetch_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(PC_W + INST_W)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(flush),
    .data_i (rd_entry),
    .count_o(fifo_count),
    .head_o (head),
    .empty_o(fifo_empty),
    .full_o (fifo_full_unused)
  );

  assign bus.valid_out = !fifo_empty;
  assign bus.inst_out  = fifo_empty ? '0 : head.inst;
  assign bus.PC_out    = fifo_empty ? '0 : head.pc;
  assign bus.running   = (state_q == StRun);

endmodule

// File: tb/tb_nq_fetch_unit.sv
// Bench for nq_fetch_unit: directed vector table, reset corner cases and a
// randomized run checked against a queue-based reference model.
module tb_nq_fetch_unit;
  import nq_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nq_fetch_unit_if bus ();
  nq_fetch_unit dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [15:0] inst;
  } ent_t;

  typedef struct {
    logic        w;
    logic [31:0] ex;
    logic        st;
    logic        rd;
    logic [31:0] pcni;
    logic        e_run;
    logic        e_val;
    logic [31:0] e_pc;
    logic [15:0] e_inst;
  } vec_t;

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Reference model: instruction memory, mode, fetch pointer, buffered entries
  // and the single outstanding read.
  logic [15:0] m_mem [256];
  logic        m_run, m_loaded, m_pend;
  logic [31:0] m_pc;
  ent_t        m_pend_e;
  ent_t        m_q[$];
  vec_t        tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic w, input logic [31:0] ex, input logic st,
                        input logic rd, input logic [31:0] pcni);
    bus.write    = w;
    bus.exInst   = ex;
    bus.stall    = st;
    bus.redirect = rd;
    bus.PCNI     = pcni;
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_loaded = 1'b0;
    m_pc = '0;
    m_pend = 1'b0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic can_issue;
    if (!m_run) begin
      if (bus.write) begin
        m_mem[bus.exInst[23:16]] = bus.exInst[15:0];
        m_loaded = 1'b1;
      end else if (m_loaded) begin
        m_run = 1'b1;
        m_pc = '0;
      end
    end else if (bus.write) begin
      m_mem[bus.exInst[23:16]] = bus.exInst[15:0];
      m_run = 1'b0;
      m_q.delete();
      m_pend = 1'b0;
    end else if (bus.redirect) begin
      m_q.delete();
      m_pend = 1'b0;
      m_pc = bus.PCNI;
    end else begin
      can_issue = (m_q.size() + int'(m_pend)) < 4;
      if (m_q.size() > 0 && !bus.stall) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_pend_e);
      m_pend = can_issue;
      if (can_issue) begin
        m_pend_e.pc = m_pc;
        m_pend_e.inst = m_mem[m_pc[7:0]];
        m_pc = m_pc + 1;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".running"}, bus.running, m_run);
    chk({tag, ".valid"}, bus.valid_out, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk({tag, ".pc"}, bus.PC_out, m_q[0].pc);
      chk({tag, ".inst"}, bus.inst_out, m_q[0].inst);
    end
  endtask

  task automatic add(input logic w, input logic [31:0] ex, input logic st, input logic rd,
                     input logic [31:0] pcni, input logic run, input logic val,
                     input logic [31:0] pc, input logic [15:0] inst);
    vec_t v;
    v.w = w; v.ex = ex; v.st = st; v.rd = rd; v.pcni = pcni;
    v.e_run = run; v.e_val = val; v.e_pc = pc; v.e_inst = inst;
    tv.push_back(v);
  endtask

  initial begin
    logic [7:0] ab;
    logic [31:0] pcni;

    // Load, then drain of four words
    add(1, 32'h0000_1111, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h0001_2222, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h0002_3333, 0, 0, 0, 0, 0, 0, 0);
    add(1, 32'h0003_4444, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 32'h0, 16'h1111);
    add(0, 0, 0, 0, 0, 1, 1, 32'h1, 16'h2222);
    // Stall six cycles with PC 1 at the head, then back-to-back drain
    for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 0, 1, 1, 32'h1, 16'h2222);
    add(0, 0, 0, 0, 0, 1, 1, 32'h2, 16'h3333);
    add(0, 0, 0, 0, 0, 1, 1, 32'h3, 16'h4444);
    add(0, 0, 0, 0, 0, 1, 1, 32'h4, 16'h5E04);
    add(0, 0, 0, 0, 0, 1, 1, 32'h5, 16'h5F05);
    // Redirect together with stall
    add(0, 0, 1, 1, 32'h20, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 32'h20, 16'h7A20);
    add(0, 0, 0, 0, 0, 1, 1, 32'h21, 16'h7B21);
    // Redirect across the IMEM index wrap
    add(0, 0, 0, 1, 32'hFF, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 32'hFF, 16'hA5FF);
    add(0, 0, 0, 0, 0, 1, 1, 32'h100, 16'h1111);
    add(0, 0, 0, 0, 0, 1, 1, 32'h101, 16'h2222);
    // Fill the FIFO, then reload during RUN
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 1, 1, 32'h101, 16'h2222);
    add(1, 32'h0000_BEEF, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 32'h0, 16'hBEEF);
    add(0, 0, 0, 0, 0, 1, 1, 32'h1, 16'h2222);

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset.valid", bus.valid_out, 0);
    chk("reset.running", bus.running, 0);
    chk("reset.pc", bus.PC_out, 0);
    chk("reset.inst", bus.inst_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // Known image everywhere: inst = {addr ^ 0x5A, addr}
    for (int a = 0; a < 256; a++) begin
      ab = 8'(a);
      set_in(1, {8'h00, ab, ab ^ 8'h5A, ab}, 0, 0, 0);
      cycle();
    end

    foreach (tv[i]) begin
      set_in(tv[i].w, tv[i].ex, tv[i].st, tv[i].rd, tv[i].pcni);
      cycle();
      chk($sformatf("vec%0d.running", i), bus.running, tv[i].e_run);
      chk($sformatf("vec%0d.valid", i), bus.valid_out, tv[i].e_val);
      if (tv[i].e_val) begin
        chk($sformatf("vec%0d.pc", i), bus.PC_out, tv[i].e_pc);
        chk($sformatf("vec%0d.inst", i), bus.inst_out, tv[i].e_inst);
      end
    end

    // Asynchronous reset in the middle of a drain
    set_in(0, 0, 0, 0, 0);
    cycle();
    cycle();
    chk_model("predrain");
    #2;
    rst = 1'b1;
    #1;
    chk("areset.valid", bus.valid_out, 0);
    chk("areset.running", bus.running, 0);
    chk("areset.pc", bus.PC_out, 0);
    chk("areset.inst", bus.inst_out, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk_model($sformatf("postrst%0d", i));
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(2))
        0: pcni = 32'($urandom_range(255));
        1: pcni = 32'hFFFF_FFF0 + 32'($urandom_range(15));
        default: pcni = $urandom();
      endcase
      set_in($urandom_range(99) < (m_run ? 2 : 40), $urandom(),
             $urandom_range(99) < 30, $urandom_range(99) < 8, pcni);
      cycle();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
